// File: rtl/run_fold_monitor_pkg.sv
// run_fold_monitor_pkg: shared FSM states, fold pipeline latency and slice-XOR helper
package run_fold_monitor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int FOLD_LAT = 2;
  localparam int FOLD_MAX_W = 1024;
  function automatic logic [31:0] fold_slices(input logic [FOLD_MAX_W-1:0] w, input int dw, input int ow);
    logic [31:0] r, m;
    r = '0;
    m = 32'((64'd1 << ow) - 64'd1);
    for (int i = 0; i < dw / ow; i++) r = r ^ (32'(w >> (i * ow)) & m);
    return r;
  endfunction
endpackage

// File: rtl/run_fold_monitor_sync.sv
// probe_sync_edge: multi-flop synchroniser with rising-edge detect on the last stage
module probe_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic last_q, last_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    last_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end
  assign rise = sync_q[STAGES-1] & ~last_q;
endmodule

// File: rtl/run_fold_monitor.sv
// run_fold_monitor: batch run controller driving ap_start/ap_done plus XOR-fold output compaction with signature
module run_fold_monitor
  import run_fold_monitor_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int OUT_WIDTH     = 4,
  parameter int SIG_WIDTH     = 16,
  parameter int SYNC_STAGES   = 3,
  parameter int RUN_CNT_WIDTH = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         probe_in,
  input  logic [RUN_CNT_WIDTH-1:0]     run_target,
  output logic                         ap_start,
  input  logic                         ap_done,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_din,
  input  logic [NUM_CH-1:0]            ch_write,
  output logic [NUM_CH-1:0]            ch_full_n,
  output logic [OUT_WIDTH-1:0]         data_out,
  output logic                         data_valid,
  output logic                         busy,
  output logic                         run_done,
  output logic [SIG_WIDTH-1:0]         sig_out,
  output logic [31:0]                  word_cnt
);
  localparam int NW  = $clog2(NUM_CH + 1);
  localparam int DCW = $clog2(FOLD_LAT);
  if (DATA_WIDTH % OUT_WIDTH != 0 || SIG_WIDTH < OUT_WIDTH || SYNC_STAGES < 2 ||
      OUT_WIDTH > 32 || DATA_WIDTH > FOLD_MAX_W) begin : g_bad_params
    $error("run_fold_monitor: invalid parameter combination");
  end
  state_t state_q, state_d;
  logic [RUN_CNT_WIDTH-1:0] tgt_q, tgt_d, run_cnt_q, run_cnt_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [NUM_CH-1:0][OUT_WIDTH-1:0] f_q, f_d;
  logic v1_q, v1_d;
  logic [NW-1:0] n1_q, n1_d, n2_q, n2_d;
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d, x;
  logic data_valid_q, data_valid_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [32:0] wsum;
  logic trig;
  probe_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(ap_clk), .rst_n(ap_rst_n), .din(probe_in), .rise(trig)
  );
  always_comb begin
    f_d = '0;
    n1_d = '0;
    x = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      f_d[c] = ch_write[c] ? OUT_WIDTH'(fold_slices(FOLD_MAX_W'(ch_din[c*DATA_WIDTH +: DATA_WIDTH]), DATA_WIDTH, OUT_WIDTH)) : '0;
      n1_d = n1_d + NW'(ch_write[c]);
      x = x ^ f_q[c];
    end
    v1_d = |ch_write;
    n2_d = n1_q;
    data_out_d = v1_q ? x : '0;
    data_valid_d = v1_q;
  end
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    run_cnt_d = run_cnt_q;
    drain_d = drain_q;
    sig_d = sig_q;
    word_cnt_d = word_cnt_q;
    wsum = {1'b0, word_cnt_q} + 33'(n2_q);
    if (state_q == IDLE && trig && run_target != '0) begin
      state_d = RUN;
      tgt_d = run_target;
      run_cnt_d = '0;
      sig_d = '0;
      word_cnt_d = '0;
    end
    if (state_q == RUN && ap_done) begin
      run_cnt_d = run_cnt_q + RUN_CNT_WIDTH'(1);
      state_d = (run_cnt_d == tgt_q) ? DRAIN : RUN;
      drain_d = '0;
    end
    if (state_q == DRAIN) begin
      drain_d = drain_q + DCW'(1);
      state_d = (drain_q == DCW'(FOLD_LAT - 1)) ? DONE : DRAIN;
    end
    if (state_q == DONE) state_d = IDLE;
    // data_out_q/n2_q are the aligned stage-2 word and its channel count
    if ((state_q == RUN || state_q == DRAIN) && data_valid_q) begin
      sig_d = {sig_q[SIG_WIDTH-2:0], sig_q[SIG_WIDTH-1]} ^ SIG_WIDTH'(data_out_q);
      word_cnt_d = wsum[32] ? '1 : wsum[31:0];
    end
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      tgt_q <= '0;
      run_cnt_q <= '0;
      drain_q <= '0;
      f_q <= '0;
      v1_q <= 1'b0;
      n1_q <= '0;
      n2_q <= '0;
      data_out_q <= '0;
      data_valid_q <= 1'b0;
      sig_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      run_cnt_q <= run_cnt_d;
      drain_q <= drain_d;
      f_q <= f_d;
      v1_q <= v1_d;
      n1_q <= n1_d;
      n2_q <= n2_d;
      data_out_q <= data_out_d;
      data_valid_q <= data_valid_d;
      sig_q <= sig_d;
      word_cnt_q <= word_cnt_d;
    end
  end
  assign ap_start = state_q == RUN;
  assign busy = state_q != IDLE;
  assign run_done = state_q == DONE;
  assign ch_full_n = '1;
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
  assign sig_out = sig_q;
  assign word_cnt = word_cnt_q;
endmodule
